// File: rtl/sys_pkg.sv
// -----------------------------------------------------------------------------
// sys_pkg
// Shared definitions for the systolic-array loader:
//   - state_t      : loader FSM state encoding
//   - DEF_*        : default bus addresses and poll timeout
//   - CTRL_START   : command byte written to the control register
//   - adr_offset() : 16-bit modulo base + offset address helper
// -----------------------------------------------------------------------------
package sys_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_A    = 4'd1,
        LOAD_B    = 4'd2,
        START     = 4'd3,
        POLL      = 4'd4,
        POLL_CHK  = 4'd5,
        DRAIN     = 4'd6,
        DRAIN_CHK = 4'd7,
        DONE      = 4'd8
    } state_t;

    localparam logic [15:0] DEF_A_BASE   = 16'h0000;
    localparam logic [15:0] DEF_B_BASE   = 16'h0100;
    localparam logic [15:0] DEF_CTRL_ADR = 16'h0200;
    localparam logic [15:0] DEF_STAT_ADR = 16'h0201;
    localparam logic [15:0] DEF_S_BASE   = 16'h0300;
    localparam logic [15:0] DEF_POLL_MAX = 16'hFFFF;

    localparam logic [7:0]  CTRL_START   = 8'h01;
    localparam int          IDX_W        = 9;
    localparam logic [1:0]  LAST_RESULT  = 2'd3;

    // Base plus a small unsigned offset; wraps modulo 2^16 by construction.
    function automatic logic [15:0] adr_offset(input logic [15:0] base,
                                               input logic [IDX_W-1:0] off);
        return base + {{(16-IDX_W){1'b0}}, off};
    endfunction

endpackage

// File: rtl/sys_loader_if.sv
// -----------------------------------------------------------------------------
// sys_loader_if
// Systolic-array register bus. Reads have a fixed latency of one cycle:
// ibus_rdata is valid in the cycle after ren is asserted.
//   ren        : read strobe          (master -> slave)
//   ibus_radr  : read address         (master -> slave)
//   ibus_rdata : read data            (slave  -> master)
//   wen        : write strobe         (master -> slave)
//   ibus_wadr  : write address        (master -> slave)
//   ibus_wdata : write data           (master -> slave)
// -----------------------------------------------------------------------------
interface sys_loader_if;

    logic        ren;
    logic [15:0] ibus_radr;
    logic [15:0] ibus_rdata;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;

    modport master (
        output ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
        input  ibus_rdata
    );

    modport slave (
        input  ren, ibus_radr, wen, ibus_wadr, ibus_wdata,
        output ibus_rdata
    );

endinterface

// File: rtl/sys_rdskid.sv
// -----------------------------------------------------------------------------
// sys_rdskid
// One-entry result holding register with a valid/ready output side.
// A load captures data/sat and raises r_valid; the entry is held unchanged
// until the consumer accepts it with r_ready.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture d_data/d_sat (only issued while the entry is empty)
//   d_data   : result word to capture
//   d_sat    : saturation flag to capture
//   r_valid  : entry holds a result
//   r_ready  : consumer accepts the result
//   r_data   : held result word
//   r_sat    : held saturation flag
// -----------------------------------------------------------------------------
module sys_rdskid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] d_data,
    input  logic        d_sat,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic        r_sat
);

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 16'd0;
            r_sat   <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d_data;
            r_sat   <= d_sat;
        end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_loader.sv
// -----------------------------------------------------------------------------
// sys_loader
// Streams 2N A-operands and 2N B-operands into a systolic array, starts it,
// polls its status register until finished (or timeout), then drains four
// result words to a valid/ready result stream.
//   clk, rst          : clock, asynchronous active-high reset
//   go, cfg_len       : start pulse and words-per-lane N (accepted in IDLE)
//   busy, done, err   : not-idle, one-cycle completion pulse, sticky error
//   s_valid/s_ready/s_data         : operand input stream
//   r_valid/r_ready/r_data/r_sat   : result output stream
//   ibus              : array register bus (master side)
// -----------------------------------------------------------------------------
module sys_loader
    import sys_pkg::*;
#(
    parameter logic [15:0] A_BASE   = DEF_A_BASE,
    parameter logic [15:0] B_BASE   = DEF_B_BASE,
    parameter logic [15:0] CTRL_ADR = DEF_CTRL_ADR,
    parameter logic [15:0] STAT_ADR = DEF_STAT_ADR,
    parameter logic [15:0] S_BASE   = DEF_S_BASE,
    parameter logic [15:0] POLL_MAX = DEF_POLL_MAX
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        go,
    input  logic [7:0]  cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err,

    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,

    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] r_data,
    output logic        r_sat,

    sys_loader_if.master ibus
);

    state_t             state, state_nxt;
    logic [7:0]         n_q;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        poll_q;
    logic [15:0]        stat_q;
    logic [1:0]         k_q;
    logic               err_q;

    logic [IDX_W-1:0]   beats_last;
    logic               go_accept, go_reject;
    logic               beat, lane_last;
    logic               poll_clr, poll_inc, poll_to, stat_cap;
    logic               skid_load, k_inc;
    logic               res_sat;

    // Index of the final beat of a lane: 2N-1 (N >= 1 is guaranteed on entry).
    assign beats_last = {1'b0, n_q} + {1'b0, n_q} - 9'd1;
    // Saturation bit for result k lives at status bit k+1 of the last poll.
    assign res_sat    = stat_q[{1'b0, k_q} + 3'd1];

    assign busy = (state != IDLE);
    assign err  = err_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, bus drive and control strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt        = state;
        s_ready          = 1'b0;
        done             = 1'b0;
        ibus.wen         = 1'b0;
        ibus.ibus_wadr   = 16'd0;
        ibus.ibus_wdata  = 16'd0;
        ibus.ren         = 1'b0;
        ibus.ibus_radr   = 16'd0;
        go_accept        = 1'b0;
        go_reject        = 1'b0;
        beat             = 1'b0;
        lane_last        = 1'b0;
        poll_clr         = 1'b0;
        poll_inc         = 1'b0;
        poll_to          = 1'b0;
        stat_cap         = 1'b0;
        skid_load        = 1'b0;
        k_inc            = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) begin
                    if (cfg_len != 8'd0) begin
                        go_accept = 1'b1;
                        state_nxt = LOAD_A;
                    end else begin
                        go_reject = 1'b1;
                    end
                end
            end

            LOAD_A, LOAD_B: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    beat            = 1'b1;
                    lane_last       = (idx_q == beats_last);
                    ibus.wen        = 1'b1;
                    ibus.ibus_wadr  = adr_offset((state == LOAD_A) ? A_BASE : B_BASE,
                                                 idx_q);
                    ibus.ibus_wdata = s_data;
                    if (lane_last) begin
                        state_nxt = (state == LOAD_A) ? LOAD_B : START;
                    end
                end
            end

            START: begin
                ibus.wen        = 1'b1;
                ibus.ibus_wadr  = CTRL_ADR;
                ibus.ibus_wdata = {CTRL_START, n_q};
                poll_clr        = 1'b1;
                state_nxt       = POLL;
            end

            POLL: begin
                ibus.ren       = 1'b1;
                ibus.ibus_radr = STAT_ADR;
                state_nxt      = POLL_CHK;
            end

            POLL_CHK: begin
                stat_cap = 1'b1;
                if (ibus.ibus_rdata[0]) begin
                    state_nxt = DRAIN;
                end else if (poll_q + 16'd1 == POLL_MAX) begin
                    poll_to   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    poll_inc  = 1'b1;
                    state_nxt = POLL;
                end
            end

            DRAIN: begin
                ibus.ren       = 1'b1;
                ibus.ibus_radr = adr_offset(S_BASE, {7'd0, k_q});
                state_nxt      = DRAIN_CHK;
            end

            // First cycle here carries the read data; capture it, then hold
            // until the consumer accepts the result.
            DRAIN_CHK: begin
                if (!r_valid) begin
                    skid_load = 1'b1;
                end else if (r_ready) begin
                    k_inc     = 1'b1;
                    state_nxt = (k_q == LAST_RESULT) ? DONE : DRAIN;
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= 8'd0;
            idx_q  <= '0;
            poll_q <= 16'd0;
            stat_q <= 16'd0;
            k_q    <= 2'd0;
            err_q  <= 1'b0;
        end else begin
            if (go_accept) begin
                n_q   <= cfg_len;
                idx_q <= '0;
                k_q   <= 2'd0;
                err_q <= 1'b0;
            end
            if (go_reject || poll_to) begin
                err_q <= 1'b1;
            end
            if (beat) begin
                idx_q <= lane_last ? '0 : idx_q + 9'd1;
            end
            if (poll_clr) begin
                poll_q <= 16'd0;
            end else if (poll_inc) begin
                poll_q <= poll_q + 16'd1;
            end
            if (stat_cap) begin
                stat_q <= ibus.ibus_rdata;
            end
            if (k_inc) begin
                k_q <= k_q + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result holding register
    // -------------------------------------------------------------------------
    sys_rdskid u_rdskid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .d_data  (ibus.ibus_rdata),
        .d_sat   (res_sat),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_sat   (r_sat)
    );

endmodule

// File: doc/sys_loader.md
SYS_LOADER -- requirements
Module: sys_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning): A_BASE 16'h0000 A-buffer base; B_BASE 16'h0100 B-buffer base; CTRL_ADR 16'h0200 control register; STAT_ADR 16'h0201 status register; S_BASE 16'h0300 result base; POLL_MAX 16'hFFFF poll timeout.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 SHALL have: go in 1 start pulse; cfg_len in 8 words per lane (N); busy out 1; done out 1 one-cycle completion pulse; err out 1 sticky error.
REQ-004 SHALL have: s_valid in 1; s_ready out 1; s_data in 16 operand stream.
REQ-005 SHALL have: r_valid out 1; r_ready in 1; r_data out 16 result stream; r_sat out 1 result saturation flag.
REQ-006 SHALL have: ren out 1; ibus_radr out 16; ibus_rdata in 16; wen out 1; ibus_wadr out 16; ibus_wdata out 16, driving the systolic array bus.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, START, POLL, POLL_CHK, DRAIN, DRAIN_CHK, DONE.
REQ-008 In IDLE, go with cfg_len!=0 SHALL latch N=cfg_len, clear err, enter LOAD_A; go with cfg_len==0 SHALL set err and stay IDLE.
REQ-009 go while busy SHALL be ignored.
REQ-010 LOAD_A: s_ready=1; each s_valid&s_ready beat SHALL issue wen=1, ibus_wadr=A_BASE+idx, ibus_wdata=s_data in the same cycle; after 2N beats, go to LOAD_B.
REQ-011 LOAD_B: identical to LOAD_A using B_BASE; after 2N beats, go to START.
REQ-012 s_ready SHALL be 0 in all states except LOAD_A/LOAD_B.
REQ-013 START: one cycle with wen=1, ibus_wadr=CTRL_ADR, ibus_wdata={8'h01,N}; then POLL with poll counter cleared.
REQ-014 POLL: ren=1, ibus_radr=STAT_ADR for one cycle; then POLL_CHK samples ibus_rdata (read latency exactly 1 cycle).
REQ-015 POLL_CHK: rdata[0]=1 -> DRAIN; else increment poll counter and return to POLL; counter reaching POLL_MAX SHALL set err and go to IDLE without done.
REQ-016 DRAIN: ren=1, ibus_radr=S_BASE+k, k=0..3; DRAIN_CHK captures rdata[15:0] into r_data and STAT bit k+1 (from last poll) into r_sat, asserts r_valid.
REQ-017 r_valid SHALL hold with r_data/r_sat stable until r_ready; after handshake, k increments; after k=3 handshake, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 wen and ren SHALL never be asserted in the same cycle; outside the cycles above both SHALL be 0 and addresses/wdata 16'd0.
REQ-021 Address arithmetic SHALL be 16-bit modulo; idx counter 9 bits (max 510).

Reset
REQ-022 rst SHALL asynchronously force IDLE, counters 0, and all outputs 0 (busy, done, err, s_ready, r_valid, r_data, r_sat, ren, wen, buses).
REQ-023 rst mid-operation SHALL abandon the transaction; no further bus write after rst asserts.

Structure
REQ-024 State encoding, default addresses and POLL_MAX SHALL reside in shared package sys_pkg.
REQ-025 One sub-module SHALL be natural: sys_rdskid, the 1-entry result holding register with valid/ready.

Verification
REQ-026 N=2, stream 8 words 0x0001..0x0008 -> writes A_BASE+0..3=1..4, B_BASE+0..3=5..8, then CTRL write 0x0102.
REQ-027 Status returns 0 twice then 0x001F -> three STAT reads, four result reads, r_sat=1 on all four, done once.
REQ-028 r_ready held low 5 cycles on first result -> r_valid and r_data stable, no second ren until handshake.
REQ-029 go with cfg_len=0 -> err=1, busy=0, no bus activity.
REQ-030 POLL_MAX=4, status always 0 -> 4 polls, err=1, IDLE, done never pulses.
REQ-031 rst asserted during LOAD_B -> next cycle all outputs 0, IDLE; new go restarts at A_BASE.
